// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: sequencer state encoding and default sizing.
package core_pkg;

    typedef enum logic [2:0] {
        SEQ_HALT   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_FAULT  = 3'd6
    } seq_state_t;

    localparam int SEQ_CNT_W       = 32;
    localparam int SEQ_MEM_TIMEOUT = 255;

    // A disabled timeout (limit 0) still gets a 1-bit counter so the port list stays legal.
    function automatic int seq_tmo_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Counts consecutive wait cycles; expire flags the cycle that would be the LIMIT-th miss.
module seq_timeout_counter
    import core_pkg::*;
#(
    parameter int LIMIT = SEQ_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic clear,
    output logic expire
);

    localparam int              W    = seq_tmo_width(LIMIT);
    localparam logic [W-1:0]    LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && !expire)
            cnt <= cnt + 1'b1;
    end

    assign expire = (LIMIT > 0) && inc && (cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: walks each instruction through fetch/decode/exec/mem/wb
// and gates the architectural write enables to fire once per instruction.
module core_sequencer
    import core_pkg::*;
#(
    parameter int CNT_W       = SEQ_CNT_W,
    parameter int MEM_TIMEOUT = SEQ_MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_wren,
    input  logic             dec_reg_wren,
    input  logic             dec_ram_wren,
    input  logic             dec_load,
    input  logic             dec_illegal,
    output logic             pc_wren,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             reg_wren,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    seq_state_t state, state_nxt;
    logic       waiting;
    logic       tmo_expire;

    // Only the two memory wait states accumulate; any other state resets the count.
    assign waiting = ((state == SEQ_FETCH) && !imem_ready) ||
                     ((state == SEQ_MEM)   && !dmem_ready);

    seq_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_tmo (
        .clk    (clk),
        .rstn   (rstn),
        .inc    (waiting),
        .clear  (!waiting),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= SEQ_HALT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            retired <= '0;
        else if (state == SEQ_WB)
            retired <= retired + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_wren   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_wren   = 1'b0;
        reg_wren  = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state)
            SEQ_HALT: begin
                halted = 1'b1;
                if (run)
                    state_nxt = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                imem_req = 1'b1;
                // Ready beats a same-cycle timeout expiry.
                if (imem_ready) begin
                    ir_wren   = 1'b1;
                    state_nxt = SEQ_DECODE;
                end else if (tmo_expire) begin
                    state_nxt = SEQ_FAULT;
                end
            end
            SEQ_DECODE: begin
                state_nxt = dec_illegal ? SEQ_FAULT : SEQ_EXEC;
            end
            SEQ_EXEC: begin
                state_nxt = (dec_load || dec_ram_wren) ? SEQ_MEM : SEQ_WB;
            end
            SEQ_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_ram_wren;
                if (dmem_ready)
                    state_nxt = SEQ_WB;
                else if (tmo_expire)
                    state_nxt = SEQ_FAULT;
            end
            SEQ_WB: begin
                pc_wren   = 1'b1;
                reg_wren  = dec_reg_wren && !dec_ram_wren;
                state_nxt = run ? SEQ_FETCH : SEQ_HALT;
            end
            SEQ_FAULT: begin
                halted = 1'b1;
                fault  = 1'b1;
            end
            default: begin
                state_nxt = SEQ_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Cycle-vector bench for core_sequencer with a short timeout and a 4-bit retire counter.
module tb_core_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0, run = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       dec_reg_wren = 1'b0, dec_ram_wren = 1'b0, dec_load = 1'b0, dec_illegal = 1'b0;
    logic       imem_req, ir_wren, pc_wren, dmem_req, dmem_we, reg_wren, halted, fault;
    logic [3:0] retired;

    int n_chk  = 0;
    int n_fail = 0;

    // in  = {rstn, run, imem_ready, dmem_ready, dec_reg_wren, dec_ram_wren, dec_load, dec_illegal}
    // exp = {imem_req, ir_wren, dmem_req, dmem_we, pc_wren, reg_wren, halted, fault}
    typedef struct {
        logic [7:0] in;
        logic [7:0] exp;
        logic [3:0] ret;
    } vec_t;

    vec_t tbl[$];

    core_sequencer #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .run          (run),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .ir_wren      (ir_wren),
        .dec_reg_wren (dec_reg_wren),
        .dec_ram_wren (dec_ram_wren),
        .dec_load     (dec_load),
        .dec_illegal  (dec_illegal),
        .pc_wren      (pc_wren),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .reg_wren     (reg_wren),
        .halted       (halted),
        .fault        (fault),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [7:0] i, input logic [7:0] e, input logic [3:0] r);
        vec_t v;
        v.in  = i;
        v.exp = e;
        v.ret = r;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [7:0] i);
        {rstn, run, imem_ready, dmem_ready, dec_reg_wren, dec_ram_wren, dec_load, dec_illegal} = i;
    endtask

    function automatic logic [7:0] outs();
        return {imem_req, ir_wren, dmem_req, dmem_we, pc_wren, reg_wren, halted, fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int pcs  = 0;
        int regs = 0;
        int reqs = 0;

        drive(8'b0000_0000);
        repeat (2) @(posedge clk);

        // reset state, then addi with zero-wait imem
        add(8'b0000_0000, 8'b0000_0010, 0);
        add(8'b1100_0000, 8'b0000_0010, 0);
        add(8'b1110_1000, 8'b1100_0000, 0);
        add(8'b1100_1000, 8'b0000_0000, 0);
        add(8'b1100_1000, 8'b0000_0000, 0);
        add(8'b1100_1000, 8'b0000_1100, 0);
        // load, dmem_ready after 3 wait cycles (also the timeout boundary)
        add(8'b1110_1010, 8'b1100_0000, 1);
        add(8'b1100_1010, 8'b0000_0000, 1);
        add(8'b1100_1010, 8'b0000_0000, 1);
        add(8'b1100_1010, 8'b0010_0000, 1);
        add(8'b1100_1010, 8'b0010_0000, 1);
        add(8'b1100_1010, 8'b0010_0000, 1);
        add(8'b1101_1010, 8'b0010_0000, 1);
        add(8'b1100_1010, 8'b0000_1100, 1);
        // store
        add(8'b1110_0100, 8'b1100_0000, 2);
        add(8'b1100_0100, 8'b0000_0000, 2);
        add(8'b1100_0100, 8'b0000_0000, 2);
        add(8'b1101_0100, 8'b0011_0000, 2);
        add(8'b1100_0100, 8'b0000_1000, 2);
        // run dropped in EXEC, then HALT and restart
        add(8'b1110_1000, 8'b1100_0000, 3);
        add(8'b1100_1000, 8'b0000_0000, 3);
        add(8'b1000_1000, 8'b0000_0000, 3);
        add(8'b1000_1000, 8'b0000_1100, 3);
        add(8'b1000_1000, 8'b0000_0010, 4);
        add(8'b1100_1000, 8'b0000_0010, 4);
        // imem ready on the 4th FETCH cycle: accepted
        add(8'b1100_1000, 8'b1000_0000, 4);
        add(8'b1100_1000, 8'b1000_0000, 4);
        add(8'b1100_1000, 8'b1000_0000, 4);
        add(8'b1110_1000, 8'b1100_0000, 4);
        add(8'b1100_1000, 8'b0000_0000, 4);
        add(8'b1100_1000, 8'b0000_0000, 4);
        add(8'b1100_1000, 8'b0000_1100, 4);
        // illegal opcode: FAULT, run/ready ignored until reset
        add(8'b1110_0000, 8'b1100_0000, 5);
        add(8'b1100_0001, 8'b0000_0000, 5);
        add(8'b1100_0000, 8'b0000_0011, 5);
        add(8'b1011_0000, 8'b0000_0011, 5);
        add(8'b1100_0000, 8'b0000_0011, 5);
        add(8'b0100_0000, 8'b0000_0011, 5);
        // imem never ready: FAULT after 4 FETCH cycles
        add(8'b1100_0000, 8'b0000_0010, 0);
        add(8'b1100_0000, 8'b1000_0000, 0);
        add(8'b1100_0000, 8'b1000_0000, 0);
        add(8'b1100_0000, 8'b1000_0000, 0);
        add(8'b1100_0000, 8'b1000_0000, 0);
        add(8'b1110_0000, 8'b0000_0011, 0);
        add(8'b0100_0000, 8'b0000_0011, 0);
        // reset during MEM
        add(8'b1100_1010, 8'b0000_0010, 0);
        add(8'b1110_1010, 8'b1100_0000, 0);
        add(8'b1100_1010, 8'b0000_0000, 0);
        add(8'b1100_1010, 8'b0000_0000, 0);
        add(8'b1100_1010, 8'b0010_0000, 0);
        add(8'b0100_1010, 8'b0010_0000, 0);
        add(8'b1000_1010, 8'b0000_0010, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].in);
            #2;
            check($sformatf("vec%0d outputs", i), 32'(outs()), 32'(tbl[i].exp));
            check($sformatf("vec%0d retired", i), 32'(retired), 32'(tbl[i].ret));
        end

        // 17 back-to-back ALU instructions wrap the 4-bit retire counter to 1
        @(negedge clk);
        drive(8'b1111_1000);
        for (int c = 0; c < 200 && pcs < 17; c++) begin
            #2;
            if (pc_wren === 1'b1) pcs++;
            if (reg_wren === 1'b1) regs++;
            if (pcs == 17) run = 1'b0;
            @(negedge clk);
        end
        #2;
        check("wrap pc_wren count", pcs, 17);
        check("wrap reg_wren count", regs, 17);
        check("wrap retired", 32'(retired), 1);
        check("wrap halted", 32'(halted), 1);

        // load whose dmem_ready never arrives: FAULT after 4 MEM cycles
        @(negedge clk);
        drive(8'b0000_0000);
        @(negedge clk);
        drive(8'b1110_1010);
        for (int c = 0; c < 50; c++) begin
            #2;
            if (fault === 1'b1) break;
            if (dmem_req === 1'b1) reqs++;
            @(negedge clk);
        end
        check("mem timeout fault", 32'(fault), 1);
        check("mem timeout dmem_req cycles", reqs, 4);
        check("mem timeout dmem_req dropped", 32'(dmem_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
